// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and the four-phase pixel encoding, used by the timing
// generator and the downstream text-mode pixel generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        TEXT_FETCH     = 2'd0,
        GLYPH_FETCH    = 2'd1,
        SET_FOREGROUND = 2'd2,
        DRAW           = 2'd3
    } pixelPhase_e;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    function automatic pixelPhase_e nextPhase(input pixelPhase_e phase);
        logic [1:0] raw;
        raw = phase + 2'd1;
        return pixelPhase_e'(raw);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with active-region and sync-pulse decode.
// Used once for the horizontal axis and once for the vertical axis.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_i,
    output logic [9:0] count_o,
    output logic       wrap_o,
    output logic       active_o,
    output logic       sync_n_o
);

    localparam int         TOTAL      = ACTIVE + FRONT + SYNC + BACK;
    localparam logic [9:0] LAST       = 10'(TOTAL - 1);
    localparam logic [9:0] ACTIVE_END = 10'(ACTIVE);
    localparam logic [9:0] SYNC_START = 10'(ACTIVE + FRONT);
    localparam logic [9:0] SYNC_END   = 10'(ACTIVE + FRONT + SYNC);

    logic [9:0] count_q;
    logic [9:0] count_d;

    assign wrap_o = step_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (step_i) begin
            count_d = wrap_o ? 10'd0 : count_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 10'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = (count_q < ACTIVE_END);
    assign sync_n_o = !((count_q >= SYNC_START) && (count_q < SYNC_END));

endmodule

// File: rtl/vga_timing_generator.sv
// Free-running VGA raster timing source with four clk phases per pixel.
// Optional frame_pulse output at the start of vertical blanking when VGA_FRAME_PULSE_EN is defined.
module vga_timing_generator #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BACK   = vga_timing_pkg::H_BACK,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BACK   = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pixel_counter,
    output logic [8:0] line_counter,
    output logic [1:0] pixel_state,
`ifdef VGA_FRAME_PULSE_EN
    output logic       frame_pulse,
`endif
    output logic       display_en,
    output logic       hsync,
    output logic       vsync
);

    import vga_timing_pkg::*;

    localparam logic [9:0] V_BLANK_START = 10'(V_ACTIVE);

    pixelPhase_e phase_q;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hStep;
    logic        hWrap;
    logic        vWrap;
    logic        hActive;
    logic        vActive;
    logic        hSyncN;
    logic        vSyncN;

    logic [9:0]  pixelCounter_q;
    logic [8:0]  lineCounter_q;
    logic [1:0]  pixelState_q;
    logic        displayEn_q;
    logic        hsync_q;
    logic        vsync_q;

    assign hStep = (phase_q == DRAW);

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) hAxis (
        .clk(clk), .reset(reset), .step_i(hStep),
        .count_o(hCount), .wrap_o(hWrap), .active_o(hActive), .sync_n_o(hSyncN)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) vAxis (
        .clk(clk), .reset(reset), .step_i(hWrap),
        .count_o(vCount), .wrap_o(vWrap), .active_o(vActive), .sync_n_o(vSyncN)
    );

    // Output stage samples the counters one edge later so that the first edge after
    // release presents pixel 0, line 0, phase 0 with display_en already high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q        <= TEXT_FETCH;
            pixelCounter_q <= 10'd0;
            lineCounter_q  <= 9'd0;
            pixelState_q   <= 2'd0;
            displayEn_q    <= 1'b0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
        end else begin
            phase_q        <= nextPhase(phase_q);
            pixelCounter_q <= hCount;
            lineCounter_q  <= vCount[8:0];
            pixelState_q   <= phase_q;
            displayEn_q    <= hActive && vActive;
            hsync_q        <= hSyncN;
            vsync_q        <= vSyncN;
        end
    end

`ifdef VGA_FRAME_PULSE_EN
    logic framePulse_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            framePulse_q <= 1'b0;
        end else begin
            framePulse_q <= (vCount == V_BLANK_START) && (hCount == 10'd0) && (phase_q == TEXT_FETCH);
        end
    end

    assign frame_pulse = framePulse_q;
`else
    logic unusedFrameDecode;
    assign unusedFrameDecode = ^{vWrap, V_BLANK_START};
`endif

    assign pixel_counter = pixelCounter_q;
    assign line_counter  = lineCounter_q;
    assign pixel_state   = pixelState_q;
    assign display_en    = displayEn_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;

endmodule
